// File: rtl/pool_window_feeder.sv
// pool_window_feeder: streams a raster feature map into 2x2 pooling windows and emits pooled pixels.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pixel_in/valid/ready        raster-order input stream with valid/ready handshake
//   input1..input4, enable      window (TL, TR, BL, BR) and one-cycle request to the pooling unit
//   pool_result, pool_done      pooled value returned by the pooling unit
//   pooled_out/valid, frame_done  downstream pooled pixel strobe and end-of-frame strobe
module pool_window_feeder #(
   parameter int data_size  = 16,
   parameter int img_width  = 8,
   parameter int img_height = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [data_size-1:0] pixel_in,
   input  logic                 pixel_valid,
   output logic                 pixel_ready,
   output logic [data_size-1:0] input1,
   output logic [data_size-1:0] input2,
   output logic [data_size-1:0] input3,
   output logic [data_size-1:0] input4,
   output logic                 enable,
   input  logic [data_size-1:0] pool_result,
   input  logic                 pool_done,
   output logic [data_size-1:0] pooled_out,
   output logic                 pooled_valid,
   output logic                 frame_done
);
   localparam int CW = $clog2(img_width);
   localparam int RW = $clog2(img_height);
   typedef enum logic [1:0] {S_RUN, S_ISSUE, S_WAIT} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [data_size-1:0] bl_q, bl_d, in1_q, in1_d, in2_q, in2_d, in3_q, in3_d, in4_q, in4_d;
   logic [data_size-1:0] pooled_q, pooled_d;
   logic valid_q, valid_d, frame_q, frame_d, last_q, last_d;
   logic [data_size-1:0] line_q [img_width];
   logic acc, col_end, row_end;
   assign pixel_ready  = state_q == S_RUN;
   assign enable       = state_q == S_ISSUE;
   assign input1       = in1_q;
   assign input2       = in2_q;
   assign input3       = in3_q;
   assign input4       = in4_q;
   assign pooled_out   = pooled_q;
   assign pooled_valid = valid_q;
   assign frame_done   = frame_q;
   assign acc          = pixel_valid && pixel_ready;
   assign col_end      = col_q == CW'(img_width - 1);
   assign row_end      = row_q == RW'(img_height - 1);
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      bl_d     = bl_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      in3_d    = in3_q;
      in4_d    = in4_q;
      pooled_d = pooled_q;
      last_d   = last_q;
      valid_d  = 1'b0;
      frame_d  = 1'b0;
      case (state_q)
         S_RUN: if (acc) begin
            col_d = col_end ? '0 : col_q + 1'b1;
            row_d = col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
            if (row_q[0] && !col_q[0]) bl_d = pixel_in;
            if (row_q[0] && col_q[0]) begin
               // odd col: col ^ 1 addresses the even (left) column of the window
               in1_d   = line_q[col_q ^ CW'(1)];
               in2_d   = line_q[col_q];
               in3_d   = bl_q;
               in4_d   = pixel_in;
               last_d  = row_end && col_end;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: if (pool_done) begin
            pooled_d = pool_result;
            valid_d  = 1'b1;
            frame_d  = last_q;
            state_d  = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_RUN;
         col_q    <= '0;
         row_q    <= '0;
         bl_q     <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         in3_q    <= '0;
         in4_q    <= '0;
         pooled_q <= '0;
         valid_q  <= 1'b0;
         frame_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         bl_q     <= bl_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         in3_q    <= in3_d;
         in4_q    <= in4_d;
         pooled_q <= pooled_d;
         valid_q  <= valid_d;
         frame_q  <= frame_d;
         last_q   <= last_d;
      end
   end
   // line buffer holds the even row; every entry is rewritten before the odd row reads it
   always_ff @(posedge clk) begin
      if (acc && !row_q[0]) line_q[col_q] <= pixel_in;
   end
endmodule

// File: tb/tb_pool_window_feeder.sv
// tb_pool_window_feeder: 2x2, 4x4 and 8x8 feeders against a behavioural frame model and a max-pool stub.
module tb_pool_window_feeder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic        vld [3];
   logic [15:0] pin [3];
   logic        rdy [3], en [3], pv [3], fd [3], pd [3];
   logic [15:0] a1 [3], a2 [3], a3 [3], a4 [3], po [3], pr [3];
   function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction
   function automatic int wof(input int i);
      return i == 0 ? 2 : i == 1 ? 4 : 8;
   endfunction
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int W = g == 0 ? 2 : g == 1 ? 4 : 8;
      logic        d;
      logic [15:0] r;
      pool_window_feeder #(.data_size(16), .img_width(W), .img_height(W)) dut (
         .clk(clk), .rst_n(rst_n), .pixel_in(pin[g]), .pixel_valid(vld[g]), .pixel_ready(rdy[g]),
         .input1(a1[g]), .input2(a2[g]), .input3(a3[g]), .input4(a4[g]), .enable(en[g]),
         .pool_result(pr[g]), .pool_done(pd[g]),
         .pooled_out(po[g]), .pooled_valid(pv[g]), .frame_done(fd[g]));
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            d <= 1'b0;
            r <= '0;
         end else begin
            d <= en[g];
            r <= mx(mx(a1[g], a2[g]), mx(a3[g], a4[g]));
         end
      end
      assign pd[g] = d;
      assign pr[g] = r;
   end
   int ncmp = 0, nerr = 0;
   int k [3], t [3], nacc [3], npv [3], nfd [3];
   logic [15:0] fr [3][64];
   logic [15:0] ew [3][4];
   logic [15:0] er [3];
   logic        el [3];
   logic [15:0] lw0 [$], lw1 [$], lr0 [$], lr1 [$];
   task automatic chk(input int i, input string nm, input logic [15:0] got, input logic [15:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL u%0d %s got %h want %h at %0t", i, nm, got, exp, $time);
      end
   endtask
   task automatic rchk();
      for (int i = 0; i < 3; i++) begin
         chk(i, "rst_ready", rdy[i], 1);
         chk(i, "rst_enable", en[i], 0);
         chk(i, "rst_pvalid", pv[i], 0);
         chk(i, "rst_fdone", fd[i], 0);
         chk(i, "rst_pout", po[i], 0);
         chk(i, "rst_in1", a1[i], 0);
         chk(i, "rst_in2", a2[i], 0);
         chk(i, "rst_in3", a3[i], 0);
         chk(i, "rst_in4", a4[i], 0);
      end
   endtask
   // t: negedges since a window pixel was accepted (0 = streaming)
   task automatic mon();
      for (int i = 0; i < 3; i++) begin
         int w, p, r, c;
         w = wof(i);
         if (!rst_n) begin
            k[i] = 0;
            t[i] = 0;
            continue;
         end
         if (t[i] == 1) begin
            chk(i, "enable", en[i], 1);
            chk(i, "ready_issue", rdy[i], 0);
            chk(i, "input1", a1[i], ew[i][0]);
            chk(i, "input2", a2[i], ew[i][1]);
            chk(i, "input3", a3[i], ew[i][2]);
            chk(i, "input4", a4[i], ew[i][3]);
            if (i == 0 && lw0.size() >= 4) begin
               chk(i, "lit_in1", a1[i], lw0.pop_front());
               chk(i, "lit_in2", a2[i], lw0.pop_front());
               chk(i, "lit_in3", a3[i], lw0.pop_front());
               chk(i, "lit_in4", a4[i], lw0.pop_front());
            end
            if (i == 1 && lw1.size() >= 4) begin
               chk(i, "lit_in1", a1[i], lw1.pop_front());
               chk(i, "lit_in2", a2[i], lw1.pop_front());
               chk(i, "lit_in3", a3[i], lw1.pop_front());
               chk(i, "lit_in4", a4[i], lw1.pop_front());
            end
         end else if (t[i] == 2) begin
            chk(i, "enable_wait", en[i], 0);
            chk(i, "ready_wait", rdy[i], 0);
            chk(i, "pvalid_wait", pv[i], 0);
         end else if (t[i] == 3) begin
            chk(i, "pvalid", pv[i], 1);
            chk(i, "pooled_out", po[i], er[i]);
            chk(i, "frame_done", fd[i], el[i]);
            chk(i, "ready_back", rdy[i], 1);
            chk(i, "enable_off", en[i], 0);
            npv[i]++;
            if (fd[i]) nfd[i]++;
            if (i == 0 && lr0.size() > 0) chk(i, "lit_pout", po[i], lr0.pop_front());
            if (i == 1 && lr1.size() > 0) chk(i, "lit_pout", po[i], lr1.pop_front());
         end else begin
            chk(i, "pvalid_idle", pv[i], 0);
            chk(i, "fdone_idle", fd[i], 0);
            chk(i, "enable_idle", en[i], 0);
            chk(i, "ready_idle", rdy[i], 1);
         end
         t[i] = (t[i] == 1 || t[i] == 2) ? t[i] + 1 : 0;
         if (t[i] == 0 && vld[i]) begin
            p = k[i] % (w * w);
            r = p / w;
            c = p % w;
            fr[i][p] = pin[i];
            k[i]++;
            nacc[i]++;
            if (r % 2 == 1 && c % 2 == 1) begin
               ew[i][0] = fr[i][p-w-1];
               ew[i][1] = fr[i][p-w];
               ew[i][2] = fr[i][p-1];
               ew[i][3] = pin[i];
               er[i] = mx(mx(ew[i][0], ew[i][1]), mx(ew[i][2], ew[i][3]));
               el[i] = p == w * w - 1;
               t[i] = 1;
            end
         end
      end
   endtask
   task automatic send(input int i, input logic [15:0] d, input int gap);
      if (gap > 0) begin
         vld[i] = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      vld[i] = 1'b1;
      pin[i] = d;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (rdy[i]) begin
            @(posedge clk);
            #1;
            return;
         end
      end
   endtask
   // mode bit0: random 0..3 idle gaps; bit1: random data (else 0,1,2,...)
   task automatic frame(input int i, input int mode, input int npix);
      for (int n = 0; n < npix; n++)
         send(i, mode[1] ? 16'($urandom) : 16'(n % 16), mode[0] ? int'($urandom_range(3, 0)) : 0);
      vld[i] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask
   initial begin
      int bpv, bfd;
      for (int i = 0; i < 3; i++) begin
         vld[i] = 1'b0;
         pin[i] = '0;
      end
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            rchk();
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            lw1 = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
            lr1 = '{5, 7, 13, 15};
            frame(1, 0, 16);
            chk(1, "frames_4x4", 16'(nfd[1]), 1);
            lw0 = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'hFFFE};
            lr0 = '{16'hFFFF};
            send(0, 16'hFFFD, 0);
            send(0, 16'hFFFF, 0);
            send(0, 16'hFFF9, 0);
            send(0, 16'hFFFE, 0);
            vld[0] = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            frame(2, 2, 64);
            chk(2, "accepts_8x8", 16'(nacc[2]), 64);
            chk(2, "pooled_8x8", 16'(npv[2]), 16);
            chk(2, "frames_8x8", 16'(nfd[2]), 1);
            lr1 = '{5, 7, 13, 15};
            frame(1, 1, 16);
            frame(2, 3, 64);
            for (int n = 0; n < 6; n++) send(1, 16'(n), 0);
            chk(1, "issue_pre_rst", en[1], 1);
            rst_n = 1'b0;
            vld[1] = 1'b0;
            #1;
            rchk();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            lr1 = '{5, 7, 13, 15};
            frame(1, 0, 16);
            bpv = npv[1];
            bfd = nfd[1];
            lr1 = '{5, 7, 13, 15, 5, 7, 13, 15};
            frame(1, 0, 32);
            chk(1, "b2b_pooled", 16'(npv[1] - bpv), 8);
            chk(1, "b2b_frames", 16'(nfd[1] - bfd), 2);
            chk(1, "lit_queue_drained", 16'(lr1.size() + lw1.size()), 0);
            chk(0, "lit_queue_drained", 16'(lr0.size() + lw0.size()), 0);
         end
         forever begin
            @(negedge clk);
            mon();
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
